// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: definitions shared by the step_ctrl execution controller.
//   state_e  : controller states (WAIT, RUN, PULSE, HALT)
//   BP_CAUSE : cause code reported when a breakpoint halts the core
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PULSE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [2:0] BP_CAUSE = 3'b111;

endpackage

// File: rtl/step_ctrl_btn_debounce.sv
// btn_debounce: synchronises and debounces the raw single-step button.
//   clk, rst  : system clock, synchronous active-high reset
//   btn_i     : raw asynchronous, bouncy button level
//   stable_o  : debounced button level
//   press_o   : one-cycle pulse on each rising edge of stable_o
// Parameter DEBOUNCE_CYCLES (>=1): consecutive differing synchronised
// samples required before stable_o follows the button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreeing sample restarts the count, which is what
    // rejects glitches shorter than DEBOUNCE_CYCLES samples.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: execution controller for the MIPS core. Gates the core clock
// enable so the CPU free-runs (switch low) or executes one instruction per
// debounced button press (switch high). Halts on an exception and latches
// the cause code and PC for the board display.
//   clk, rst        : system clock, synchronous active-high reset
//   singlestep_sw   : 1 = step mode, 0 = run mode (asynchronous level)
//   singlestep_btn  : raw step button (asynchronous, bouncy)
//   pc_in           : PC of the instruction executed while cpu_en=1
//   exc_valid       : exception raised in this enabled cycle
//   exc_cause       : exception cause, valid with exc_valid
//   bp_addr         : breakpoint address (breakpoint build only)
//   cpu_en          : core clock enable
//   halted          : controller is in HALT
//   causeout, PCout : latched halt cause and PC
//   step_count      : number of single steps issued (wraps)
//   dbg_state       : current controller state (state_e encoding)
// Optional feature: define STEP_CTRL_BREAKPOINT_EN to halt when an enabled
// cycle executes pc_in == bp_addr (cause BP_CAUSE; an exception wins).
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             singlestep_sw,
    input  logic             singlestep_btn,
    input  logic [31:0]      pc_in,
    input  logic             exc_valid,
    input  logic [2:0]       exc_cause,
    input  logic [31:0]      bp_addr,
    output logic             cpu_en,
    output logic             halted,
    output logic [2:0]       causeout,
    output logic [31:0]      PCout,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       dbg_state
);

    state_e             state_q, state_d;
    logic               sw_meta_q, sw_sync_q;
    logic               press;
    logic               btn_stable;
    logic               bp_hit;
    logic [2:0]         cause_q, cause_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (singlestep_btn),
        .stable_o (btn_stable),
        .press_o  (press)
    );

`ifdef STEP_CTRL_BREAKPOINT_EN
    logic unused_stable;
    assign unused_stable = btn_stable;
    assign bp_hit        = (pc_in == bp_addr);
`else
    logic unused_inputs;
    assign unused_inputs = btn_stable ^ (^bp_addr);
    assign bp_hit        = 1'b0;
`endif

    // Exceptions and breakpoints are only evaluated in RUN and PULSE, the
    // two states in which cpu_en is high, so disabled cycles never halt.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (!sw_sync_q) begin
                    state_d = ST_RUN;
                end else if (press) begin
                    state_d = ST_PULSE;
                end
            end
            ST_RUN: begin
                if (exc_valid) begin
                    state_d = ST_HALT;
                    cause_d = exc_cause;
                    pc_d    = pc_in;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = BP_CAUSE;
                    pc_d    = pc_in;
                end else if (sw_sync_q) begin
                    state_d = ST_WAIT;
                end
            end
            ST_PULSE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (exc_valid) begin
                    state_d = ST_HALT;
                    cause_d = exc_cause;
                    pc_d    = pc_in;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = BP_CAUSE;
                    pc_d    = pc_in;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            sw_meta_q <= 1'b0;
            sw_sync_q <= 1'b0;
            cause_q   <= 3'd0;
            pc_q      <= 32'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sw_meta_q <= singlestep_sw;
            sw_sync_q <= sw_meta_q;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Pure decode of the state register: no input reaches cpu_en
    // combinationally.
    assign cpu_en     = (state_q == ST_RUN) || (state_q == ST_PULSE);
    assign halted     = (state_q == ST_HALT);
    assign causeout   = cause_q;
    assign PCout      = pc_q;
    assign step_count = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: scoreboard bench for step_ctrl (DEBOUNCE_CYCLES=2, CNT_W=16).
// The driver schedules expected output snapshots tagged with the clock edge
// after which they must hold; a monitor on the falling edge pops and
// compares them against the DUT.
module tb_step_ctrl;
    import step_ctrl_pkg::*;

    localparam int OBS_W = 55;  // state2, en, halted, cause3, pc32, count16

    logic        clk = 1'b0;
    logic        rst;
    logic        sw;
    logic        btn;
    logic [31:0] pc;
    logic        exc;
    logic [2:0]  cause;
    logic [31:0] bp;
    logic        cpu_en;
    logic        halted;
    logic [2:0]  causeout;
    logic [31:0] pcout;
    logic [15:0] step_count;
    logic [1:0]  dbg_state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [OBS_W-1:0] exp_q[$];
    int               tag_q[$];
    string            name_q[$];

    step_ctrl #(
        .DEBOUNCE_CYCLES (2),
        .CNT_W           (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .singlestep_sw  (sw),
        .singlestep_btn (btn),
        .pc_in          (pc),
        .exc_valid      (exc),
        .exc_cause      (cause),
        .bp_addr        (bp),
        .cpu_en         (cpu_en),
        .halted         (halted),
        .causeout       (causeout),
        .PCout          (pcout),
        .step_count     (step_count),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [OBS_W-1:0] mk(input logic [1:0] st, input logic en,
                                            input logic h, input logic [2:0] c,
                                            input logic [31:0] p, input logic [15:0] n);
        return {st, en, h, c, p, n};
    endfunction

    task automatic expect_at(input int at, input logic [OBS_W-1:0] v, input string nm);
        tag_q.push_back(at);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges with step mode selected; the switch synchroniser
    // restarts at 0, so allow it to settle back into WAIT.
    task automatic do_reset();
        rst = 1'b1;
        sw  = 1'b1;
        btn = 1'b0;
        exc = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (6) step();
    endtask

    // One full press: button high 4 cycles, low 4 cycles. cpu_en must pulse
    // for exactly the cycle after the 5th edge following the drive point.
    task automatic press_step(input logic [15:0] cnt_before);
        int c;
        c = cyc;
        btn = 1'b1;
        expect_at(c + 4, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, cnt_before), "step_pre");
        expect_at(c + 5, mk(ST_PULSE, 1'b1, 1'b0, 3'd0, 32'd0, cnt_before), "step_pulse");
        expect_at(c + 6, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, cnt_before + 16'd1), "step_post");
        repeat (4) step();
        btn = 1'b0;
        repeat (4) step();
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [OBS_W-1:0] mon_obs;
    logic [OBS_W-1:0] mon_exp;
    int               mon_tag;
    string            mon_name;

    always @(negedge clk) begin
        mon_obs = {dbg_state, cpu_en, halted, causeout, pcout, step_count};
        while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
            mon_tag  = tag_q.pop_front();
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            n_checks++;
            if (mon_tag < cyc) begin
                n_fail++;
                $display("FAIL %s: check for edge %0d not evaluated (now %0d)", mon_name, mon_tag, cyc);
            end else if (mon_obs !== mon_exp) begin
                n_fail++;
                $display("FAIL %s @edge %0d: got st=%0d en=%0b halt=%0b cause=%0d pc=%h cnt=%0d, expected st=%0d en=%0b halt=%0b cause=%0d pc=%h cnt=%0d",
                         mon_name, cyc,
                         mon_obs[54:53], mon_obs[52], mon_obs[51], mon_obs[50:48], mon_obs[47:16], mon_obs[15:0],
                         mon_exp[54:53], mon_exp[52], mon_exp[51], mon_exp[50:48], mon_exp[47:16], mon_exp[15:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        rst   = 1'b1;
        sw    = 1'b1;
        btn   = 1'b0;
        pc    = 32'd0;
        exc   = 1'b0;
        cause = 3'd0;
        bp    = 32'h0000_0010;
        step();
        step();
        expect_at(cyc, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "reset_state");
        step();

        // Five single steps.
        do_reset();
        expect_at(cyc, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "idle_after_reset");
        for (int i = 0; i < 5; i++) begin
            press_step(16'(i));
        end
        expect_at(cyc, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd5), "five_steps");
        step();

        // One-sample glitch must be rejected.
        do_reset();
        c = cyc;
        for (int k = 1; k <= 10; k++) begin
            expect_at(c + k, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "short_pulse");
        end
        btn = 1'b1;
        step();
        btn = 1'b0;
        repeat (10) step();

        // Exception while disabled is ignored.
        exc   = 1'b1;
        cause = 3'd5;
        pc    = 32'h0000_0080;
        c = cyc;
        for (int k = 1; k <= 3; k++) begin
            expect_at(c + k, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "exc_when_disabled");
        end
        repeat (3) step();
        exc = 1'b0;
        pc  = 32'd0;

        // Run mode enter / leave / re-enter.
        c = cyc;
        sw = 1'b0;
        expect_at(c + 2, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "run_latency_pre");
        expect_at(c + 3, mk(ST_RUN, 1'b1, 1'b0, 3'd0, 32'd0, 16'd0), "run_entry");
        expect_at(c + 4, mk(ST_RUN, 1'b1, 1'b0, 3'd0, 32'd0, 16'd0), "run_hold");
        repeat (5) step();
        c = cyc;
        sw = 1'b1;
        expect_at(c + 2, mk(ST_RUN, 1'b1, 1'b0, 3'd0, 32'd0, 16'd0), "run_exit_pre");
        expect_at(c + 3, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "run_exit");
        repeat (5) step();
        sw = 1'b0;
        repeat (5) step();

`ifdef STEP_CTRL_BREAKPOINT_EN
        // Breakpoint halt, then exception winning over breakpoint.
        c = cyc;
        pc = 32'h0000_0010;
        expect_at(c + 1, mk(ST_HALT, 1'b0, 1'b1, 3'd7, 32'h10, 16'd0), "bp_halt");
        step();
        pc = 32'd0;
        step();
        do_reset();
        sw = 1'b0;
        repeat (5) step();
        c = cyc;
        pc    = 32'h0000_0010;
        exc   = 1'b1;
        cause = 3'd2;
        expect_at(c + 1, mk(ST_HALT, 1'b0, 1'b1, 3'd2, 32'h10, 16'd0), "bp_exc_priority");
        step();
        exc = 1'b0;
        pc  = 32'd0;
        do_reset();
        sw = 1'b0;
        repeat (5) step();
`else
        // Without the breakpoint feature a matching PC does not halt.
        c = cyc;
        pc = 32'h0000_0010;
        expect_at(c + 1, mk(ST_RUN, 1'b1, 1'b0, 3'd0, 32'd0, 16'd0), "no_bp_halt");
        expect_at(c + 2, mk(ST_RUN, 1'b1, 1'b0, 3'd0, 32'd0, 16'd0), "no_bp_halt_hold");
        repeat (2) step();
        pc = 32'd0;
`endif

        // Exception in run mode halts and captures; everything else ignored.
        c = cyc;
        pc    = 32'h0000_0040;
        exc   = 1'b1;
        cause = 3'd4;
        expect_at(c + 1, mk(ST_HALT, 1'b0, 1'b1, 3'd4, 32'h40, 16'd0), "exc_halt");
        step();
        exc   = 1'b0;
        cause = 3'd1;
        pc    = 32'h0000_0044;
        sw    = 1'b1;
        btn   = 1'b1;
        repeat (4) step();
        btn = 1'b0;
        repeat (4) step();
        sw    = 1'b0;
        exc   = 1'b1;
        cause = 3'd6;
        repeat (4) step();
        exc = 1'b0;
        c = cyc;
        expect_at(c + 1, mk(ST_HALT, 1'b0, 1'b1, 3'd4, 32'h40, 16'd0), "halt_sticky");
        step();

        // Reset one cycle into a pulse clears everything on the next edge.
        do_reset();
        press_step(16'd0);
        c = cyc;
        btn = 1'b1;
        expect_at(c + 5, mk(ST_PULSE, 1'b1, 1'b0, 3'd0, 32'd0, 16'd1), "pulse_before_rst");
        expect_at(c + 6, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "rst_mid_pulse");
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        btn = 1'b0;
        repeat (6) step();
        expect_at(cyc, mk(ST_WAIT, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0), "idle_after_rst_pulse");
        step();

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && tag_q.size() > 0; k++) begin
            step();
        end
        while (tag_q.size() > 0) begin
            void'(tag_q.pop_front());
            void'(exp_q.pop_front());
            mon_name = name_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected snapshot never evaluated", mon_name);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
